// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller.
// Holds the FSM state encoding, the default parameter values and the
// select-index width helper.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

  localparam int CREDIT_W_DEF = 8;
  localparam int N_ITEMS_DEF  = 4;
  localparam int STOCK_W_DEF  = 4;

  // Width of an item index; never narrower than one bit.
  function automatic int sel_width(input int n_items);
    return (n_items > 1) ? $clog2(n_items) : 1;
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters for the vending controller (VEND_STOCK_EN builds only).
// Each counter starts full, loses one unit per acknowledged vend and is
// refilled to all-ones by restock. A refill wins over a simultaneous vend.
module vend_stock
  import vend_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int STOCK_W = STOCK_W_DEF,
  parameter int SEL_W   = sel_width(N_ITEMS_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic [SEL_W-1:0]   dec_idx,
  input  logic               restock,
  input  logic [SEL_W-1:0]   restock_idx,
  output logic [N_ITEMS-1:0] empty
);

  logic [STOCK_W-1:0] cnt_r [N_ITEMS];

  // Counter update: reset/restock fill, acknowledged vend consumes one unit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (!rst) begin
        cnt_r[i] <= '1;
      end else if (restock && (restock_idx == SEL_W'(i))) begin
        cnt_r[i] <= '1;
      end else if (dec && (dec_idx == SEL_W'(i)) && (cnt_r[i] != '0)) begin
        cnt_r[i] <= cnt_r[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_empty
    assign empty[g] = (cnt_r[g] == '0);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, vends a selected item
// through a valid/ack handshake and returns change or refunds.
// Optional feature macro VEND_STOCK_EN adds per-item stock counting
// (vend_stock); without it items are never sold out and restock is ignored.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter  int CREDIT_W = CREDIT_W_DEF,
  parameter  int N_ITEMS  = N_ITEMS_DEF,
  parameter  int STOCK_W  = STOCK_W_DEF,
  localparam int SEL_W    = sel_width(N_ITEMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_valid,
  input  logic [CREDIT_W-1:0]         coin_val,
  input  logic                        sel_valid,
  input  logic [SEL_W-1:0]            sel_idx,
  input  logic                        cancel,
  input  logic [N_ITEMS*CREDIT_W-1:0] price,
  input  logic                        restock,
  input  logic [SEL_W-1:0]            restock_idx,
  input  logic                        vend_ack,
  output logic                        vend_valid,
  output logic [SEL_W-1:0]            vend_idx,
  output logic                        change_valid,
  output logic [CREDIT_W-1:0]         change_amt,
  output logic                        coin_rej,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        busy
);

  localparam int NSEL = 2 ** SEL_W;

  vend_state_t          state_r;
  logic [CREDIT_W:0]    coin_sum_s;
  logic                 coin_ovf_s;
  logic [CREDIT_W-1:0]  price_arr_s [NSEL];
  logic                 sel_in_range_s;
  logic [CREDIT_W-1:0]  sel_price_s;
  logic                 sold_out_s;
  logic                 sel_ok_s;

  // Price table padded to every encodable index; unused slots read zero.
  for (genvar g = 0; g < NSEL; g++) begin : g_price
    if (g < N_ITEMS) begin : g_real
      assign price_arr_s[g] = price[g*CREDIT_W +: CREDIT_W];
    end else begin : g_pad
      assign price_arr_s[g] = '0;
    end
  end

`ifdef VEND_STOCK_EN
  logic [N_ITEMS-1:0] empty_s;
  logic [NSEL-1:0]    empty_pad_s;

  vend_stock #(
    .N_ITEMS (N_ITEMS),
    .STOCK_W (STOCK_W),
    .SEL_W   (SEL_W)
  ) u_stock (
    .clk         (clk),
    .rst         (rst),
    .dec         (vend_ack && (state_r == ST_VEND)),
    .dec_idx     (vend_idx),
    .restock     (restock),
    .restock_idx (restock_idx),
    .empty       (empty_s)
  );

  assign empty_pad_s = NSEL'(empty_s);
  assign sold_out_s  = empty_pad_s[sel_idx];
`else
  logic                 unused_restock_s;
  logic [STOCK_W-1:0]   unused_stock_s;
  assign unused_restock_s = ^{restock, restock_idx};
  assign unused_stock_s   = '0;
  assign sold_out_s       = 1'b0;
`endif

  // Coin acceptance arithmetic and selection qualification.
  always_comb begin
    coin_sum_s     = {1'b0, credit} + {1'b0, coin_val};
    coin_ovf_s     = coin_sum_s[CREDIT_W];
    sel_in_range_s = ({1'b0, sel_idx} < (SEL_W+1)'(N_ITEMS));
    if (sel_in_range_s) begin
      sel_price_s = price_arr_s[sel_idx];
    end else begin
      sel_price_s = '0;
    end
    sel_ok_s = sel_valid && sel_in_range_s && (sel_price_s <= credit) && !sold_out_s;
  end

  // Main FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_rej     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_rej     <= 1'b0;
      case (state_r)
        ST_IDLE, ST_CREDIT: begin
          if (cancel) begin
            coin_rej <= coin_valid;
            if (state_r == ST_CREDIT) begin
              change_valid <= 1'b1;
              change_amt   <= credit;
              credit       <= '0;
              state_r      <= ST_IDLE;
            end
          end else if (sel_valid) begin
            coin_rej <= coin_valid;
            if (sel_ok_s) begin
              vend_valid <= 1'b1;
              vend_idx   <= sel_idx;
              credit     <= credit - sel_price_s;
              busy       <= 1'b1;
              state_r    <= ST_VEND;
            end
          end else if (coin_valid) begin
            if (coin_ovf_s) begin
              coin_rej <= 1'b1;
            end else begin
              credit  <= coin_sum_s[CREDIT_W-1:0];
              state_r <= ST_CREDIT;
            end
          end
        end
        ST_VEND: begin
          coin_rej <= coin_valid;
          if (vend_ack) begin
            vend_valid <= 1'b0;
            vend_idx   <= '0;
            if (credit == '0) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_CHANGE;
            end
          end
        end
        ST_CHANGE: begin
          coin_rej     <= coin_valid;
          change_valid <= 1'b1;
          change_amt   <= credit;
          credit       <= '0;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          vend_valid <= 1'b0;
          vend_idx   <= '0;
          credit     <= '0;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed, table-driven bench for vend_ctrl (prices 5,10,20,40).
// With VEND_STOCK_EN defined it also exercises the stock counters (STOCK_W=2).
module tb_vend_ctrl;

  localparam int CW = 8;
  localparam int NI = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin_valid;
  logic [CW-1:0] coin_val;
  logic          sel_valid;
  logic [1:0]    sel_idx;
  logic          cancel;
  logic [NI*CW-1:0] price;
  logic          restock;
  logic [1:0]    restock_idx;
  logic          vend_ack;
  logic          vend_valid;
  logic [1:0]    vend_idx;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic          coin_rej;
  logic [CW-1:0] credit;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rs;
    logic       cv;
    logic [7:0] cval;
    logic       sv;
    logic [1:0] sidx;
    logic       can;
    logic       ack;
    logic       e_vv;
    logic [1:0] e_vi;
    logic       e_cv;
    logic [7:0] e_ca;
    logic       e_cr;
    logic [7:0] e_credit;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  vend_ctrl #(.CREDIT_W(CW), .N_ITEMS(NI), .STOCK_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .price        (price),
    .restock      (restock),
    .restock_idx  (restock_idx),
    .vend_ack     (vend_ack),
    .vend_valid   (vend_valid),
    .vend_idx     (vend_idx),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_rej     (coin_rej),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic cv, input logic [7:0] cval,
                      input logic sv, input logic [1:0] sidx, input logic can,
                      input logic ack, input logic rstk, input logic [1:0] ridx);
    rst = rs; coin_valid = cv; coin_val = cval; sel_valid = sv; sel_idx = sidx;
    cancel = can; vend_ack = ack; restock = rstk; restock_idx = ridx;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rs, input logic cv, input logic [7:0] cval,
                     input logic sv, input logic [1:0] sidx, input logic can, input logic ack,
                     input logic e_vv, input logic [1:0] e_vi, input logic e_cv,
                     input logic [7:0] e_ca, input logic e_cr, input logic [7:0] e_credit,
                     input logic e_busy);
    vec_t v;
    v = '{rs, cv, cval, sv, sidx, can, ack, e_vv, e_vi, e_cv, e_ca, e_cr, e_credit, e_busy};
    vq.push_back(v);
  endtask

  task automatic check_all(input int idx, input logic e_vv, input logic [1:0] e_vi,
                           input logic e_cv, input logic [7:0] e_ca, input logic e_cr,
                           input logic [7:0] e_credit, input logic e_busy);
    chk("vend_valid", idx, 32'(vend_valid), 32'(e_vv));
    chk("vend_idx", idx, 32'(vend_idx), 32'(e_vi));
    chk("change_valid", idx, 32'(change_valid), 32'(e_cv));
    chk("change_amt", idx, 32'(change_amt), 32'(e_ca));
    chk("coin_rej", idx, 32'(coin_rej), 32'(e_cr));
    chk("credit", idx, 32'(credit), 32'(e_credit));
    chk("busy", idx, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    price = {8'd40, 8'd20, 8'd10, 8'd5};
    rst = 1'b0; coin_valid = 1'b0; coin_val = 8'd0; sel_valid = 1'b0; sel_idx = 2'd0;
    cancel = 1'b0; vend_ack = 1'b0; restock = 1'b0; restock_idx = 2'd0;

    //  rs cv cval sv si can ack | vv vi cv ca  cr credit busy
    add(0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0);  // reset state
    add(1, 1,  10, 0, 0, 0, 0,   0, 0, 0,   0, 0,  10, 0);
    add(1, 1,  10, 0, 0, 0, 0,   0, 0, 0,   0, 0,  20, 0);
    add(1, 0,   0, 1, 2, 0, 0,   1, 2, 0,   0, 0,   0, 1);  // buy item 2 (20)
    add(1, 0,   0, 0, 0, 0, 0,   1, 2, 0,   0, 0,   0, 1);
    add(1, 0,   0, 0, 0, 0, 0,   1, 2, 0,   0, 0,   0, 1);
    add(1, 0,   0, 0, 0, 0, 1,   0, 0, 0,   0, 0,   0, 0);  // ack, no change
    add(1, 1,  50, 0, 0, 0, 0,   0, 0, 0,   0, 0,  50, 0);
    add(1, 0,   0, 1, 1, 0, 0,   1, 1, 0,   0, 0,  40, 1);  // buy item 1 (10)
    add(1, 0,   0, 0, 0, 0, 1,   0, 0, 0,   0, 0,  40, 1);  // ack -> CHANGE
    add(1, 0,   0, 0, 0, 0, 0,   0, 0, 1,  40, 0,   0, 0);  // change 40
    add(1, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0);  // change_amt back to 0
    add(1, 1, 200, 0, 0, 0, 0,   0, 0, 0,   0, 0, 200, 0);
    add(1, 1,  50, 0, 0, 0, 0,   0, 0, 0,   0, 0, 250, 0);
    add(1, 1,  10, 0, 0, 0, 0,   0, 0, 0,   0, 1, 250, 0);  // overflow reject
    add(1, 1,   5, 0, 0, 0, 0,   0, 0, 0,   0, 0, 255, 0);  // exactly max
    add(1, 1,   1, 0, 0, 0, 0,   0, 0, 0,   0, 1, 255, 0);  // overflow by one
    add(1, 1,   5, 0, 0, 1, 0,   0, 0, 1, 255, 1,   0, 0);  // cancel + coin
    add(1, 0,   0, 0, 0, 1, 0,   0, 0, 0,   0, 0,   0, 0);  // cancel in IDLE
    add(1, 1,  30, 0, 0, 0, 0,   0, 0, 0,   0, 0,  30, 0);
    add(1, 0,   0, 1, 3, 0, 0,   0, 0, 0,   0, 0,  30, 0);  // price 40 > 30
    add(1, 1,  10, 1, 1, 0, 0,   1, 1, 0,   0, 1,  20, 1);  // coin+select
    add(1, 1,  10, 1, 0, 1, 0,   1, 1, 0,   0, 1,  20, 1);  // inputs ignored in VEND
    add(1, 0,   0, 0, 0, 0, 1,   0, 0, 0,   0, 0,  20, 1);
    add(1, 1,   5, 0, 0, 0, 0,   0, 0, 1,  20, 1,   0, 0);  // coin in CHANGE
    add(1, 1,  30, 0, 0, 0, 0,   0, 0, 0,   0, 0,  30, 0);
    add(1, 0,   0, 0, 0, 1, 0,   0, 0, 1,  30, 0,   0, 0);  // refund 30
    add(1, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0);
    add(1, 1,  40, 0, 0, 0, 0,   0, 0, 0,   0, 0,  40, 0);
    add(1, 0,   0, 1, 3, 0, 0,   1, 3, 0,   0, 0,   0, 1);  // price == credit
    add(0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0);  // reset mid-VEND
    add(1, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0);  // no change pulse

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rs, vq[i].cv, vq[i].cval, vq[i].sv, vq[i].sidx, vq[i].can, vq[i].ack, 1'b0, 2'd0);
      check_all(i, vq[i].e_vv, vq[i].e_vi, vq[i].e_cv, vq[i].e_ca, vq[i].e_cr, vq[i].e_credit, vq[i].e_busy);
    end

    // Long dispenser wait: request must stay stable for many cycles.
    step(1'b1, 1'b1, 8'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 12; k++) begin
      chk("hold_vv", 100 + k, 32'(vend_valid), 32'd1);
      chk("hold_vi", 100 + k, 32'(vend_idx), 32'd2);
      step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    check_all(200, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 8'd5, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_all(201, 1'b0, 2'd0, 1'b1, 8'd5, 1'b0, 8'd0, 1'b0);

`ifdef VEND_STOCK_EN
    // Stock: STOCK_W=2 gives three units of item 0 after reset.
    step(1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("stock_vend", 300 + k, 32'(vend_valid), 32'd1);
      step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    end
    step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("soldout_vv", 310, 32'(vend_valid), 32'd0);
    chk("soldout_credit", 310, 32'(credit), 32'd5);
    step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("restock_vv", 311, 32'(vend_valid), 32'd1);
    // Ack together with restock of the same item leaves the counter full.
    step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("refill_vend", 320 + k, 32'(vend_valid), 32'd1);
      step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    end
    step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("refill_soldout", 330, 32'(vend_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
